// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: turns pipeline MemRead/MemWrite into a
// held req/ack transaction, stalls the pipeline until it completes, aborts on ack timeout.
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  access;

  assign access = MemRead_i | MemWrite_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = MemWrite_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An ack arriving on the last allowed cycle still counts as success.
        if (mem_ack_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata_i;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
          if (!we_q) rdata_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // DONE deliberately drops stall so the pipeline advances past the finished access.
  assign stall_o     = ((state_q == IDLE) && access) || (state_q == WAIT);
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: driver pushes expected memory requests and
// completions, a negedge monitor pops and compares; a responder models the memory.
module tb_dmem_access_ctrl;

  localparam int TO   = 16;
  localparam int NONE = 1000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          stall;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        err_o;

  dmem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad = 0;
  req_t        req_exp[$];
  done_t       done_exp[$];
  bit          mon_en = 1'b0;
  bit          spur_en = 1'b0;
  bit          ack_now = 1'b0;
  int          ack_delay = NONE;
  logic [31:0] resp_data = '0;
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks the k-th cycle of a request, plus random acks while no request is out.
  initial begin
    int n;
    n = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      mem_rdata_i = $urandom;
      if (ack_now) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hCAFEF00D;
        ack_now = 1'b0;
      end else if (mem_req_o) begin
        if (n == ack_delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = resp_data;
        end
        n++;
      end else begin
        n = 0;
        if (spur_en && $urandom_range(0, 5) == 0) mem_ack_i = 1'b1;
      end
    end
  end

  initial begin
    req_t        r;
    done_t       d;
    bit          req_prev;
    int          stall_cnt;
    logic        held_we;
    logic [31:0] held_addr, held_wdata;
    req_prev = 1'b0;
    stall_cnt = 0;
    held_we = 1'b0;
    held_addr = '0;
    held_wdata = '0;
    forever begin
      @(negedge clk_i);
      if (!mon_en) begin
        req_prev = 1'b0;
        stall_cnt = 0;
      end else begin
        if (mem_req_o && !req_prev) begin
          if (req_exp.size() == 0) check_output("req_unexpected", 32'd1, 32'd0);
          else begin
            r = req_exp.pop_front();
            check_output("req_we", mem_we_o, r.we);
            check_output("req_addr", mem_addr_o, r.addr);
            check_output("req_wdata", mem_wdata_o, r.wdata);
            held_we = r.we;
            held_addr = r.addr;
            held_wdata = r.wdata;
          end
        end else if (mem_req_o) begin
          check_output("hold_we", mem_we_o, held_we);
          check_output("hold_addr", mem_addr_o, held_addr);
          check_output("hold_wdata", mem_wdata_o, held_wdata);
        end
        if (stall_o) stall_cnt++;
        else if (stall_cnt > 0) begin
          if (done_exp.size() == 0) check_output("done_unexpected", 32'd1, 32'd0);
          else begin
            d = done_exp.pop_front();
            check_output("stall_len", stall_cnt, d.stall);
            check_output("done_rdata", rdata_o, d.rdata);
            check_output("done_err", err_o, d.err);
            check_output("done_req_low", mem_req_o, 1'b0);
          end
          stall_cnt = 0;
        end
        req_prev = mem_req_o;
      end
    end
  end

  // Expected stall: 2+k cycles on an ack after k waits, TO+1 cycles on timeout.
  task automatic apply_stimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int delay,
                                input logic [31:0] rdat, input int gap);
    int cycles;
    @(posedge clk_i); #1;
    ack_delay = delay;
    resp_data = rdat;
    MemRead_i = rd;
    MemWrite_i = wr;
    addr_i = addr;
    wdata_i = wdata;
    req_exp.push_back('{we: wr, addr: addr, wdata: wdata});
    if (delay >= TO) begin
      model_err = 1'b1;
      if (!wr) model_rdata = '0;
      done_exp.push_back('{stall: TO + 1, rdata: model_rdata, err: model_err});
    end else begin
      if (!wr) model_rdata = rdat;
      done_exp.push_back('{stall: delay + 2, rdata: model_rdata, err: model_err});
    end
    cycles = 0;
    do begin
      @(posedge clk_i); #1;
      cycles++;
      if (stall_o) begin
        addr_i = $urandom;
        wdata_i = $urandom;
      end
    end while (stall_o && cycles < 60);
    check_output("stall_budget", (cycles < 60) ? 32'd1 : 32'd0, 32'd1);
    repeat (gap) begin
      @(posedge clk_i); #1;
      MemRead_i = 1'b0;
      MemWrite_i = 1'b0;
      addr_i = $urandom;
      wdata_i = $urandom;
    end
  endtask

  initial begin
    int kind, dly;
    rst_i = 1'b1;
    MemRead_i = 1'b0;
    MemWrite_i = 1'b0;
    addr_i = '0;
    wdata_i = '0;
    #3;
    check_output("rst_req", mem_req_o, 1'b0);
    check_output("rst_we", mem_we_o, 1'b0);
    check_output("rst_addr", mem_addr_o, 32'd0);
    check_output("rst_wdata", mem_wdata_o, 32'd0);
    check_output("rst_rdata", rdata_o, 32'd0);
    check_output("rst_err", err_o, 1'b0);
    check_output("rst_stall", stall_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mon_en = 1'b1;
    spur_en = 1'b1;

    apply_stimulus(1, 0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 2);
    apply_stimulus(0, 1, 32'h80, 32'h12345678, 3, 32'h55555555, 0);
    apply_stimulus(1, 0, 32'h100, 32'h0, NONE, 32'h0, 0);
    apply_stimulus(1, 0, 32'h104, 32'h0, 2, 32'h0BADF00D, 0);
    apply_stimulus(1, 0, 32'h200, 32'h0, 0, 32'hA5A5A5A5, 0);
    apply_stimulus(0, 1, 32'h204, 32'hFEEDFACE, 1, 32'h0, 1);
    apply_stimulus(1, 1, 32'h300, 32'h01020304, 1, 32'h77777777, 1);
    apply_stimulus(0, 1, 32'h304, 32'h0, TO - 1, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      dly = ($urandom_range(0, 5) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 6);
      apply_stimulus(kind != 1, kind != 0, $urandom, $urandom, dly, $urandom,
                     $urandom_range(0, 2));
    end
    @(posedge clk_i); #1;
    MemRead_i = 1'b0;
    MemWrite_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_output("req_queue_drained", req_exp.size(), 32'd0);
    check_output("done_queue_drained", done_exp.size(), 32'd0);

    mon_en = 1'b0;
    spur_en = 1'b0;
    ack_delay = NONE;
    @(posedge clk_i); #1;
    MemRead_i = 1'b1;
    addr_i = 32'h400;
    @(posedge clk_i); #1;
    @(posedge clk_i); #2;
    check_output("pre_rst_req", mem_req_o, 1'b1);
    rst_i = 1'b1;
    MemRead_i = 1'b0;
    #1;
    check_output("midrst_req", mem_req_o, 1'b0);
    check_output("midrst_stall", stall_o, 1'b0);
    check_output("midrst_rdata", rdata_o, 32'd0);
    check_output("midrst_err", err_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ack_now = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      check_output("postrst_req", mem_req_o, 1'b0);
      check_output("postrst_stall", stall_o, 1'b0);
      check_output("postrst_rdata", rdata_o, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
